// File: rtl/patseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : patseq_pkg
//  Description : Shared types and helpers for the pattern sequence generator.
//                Provides the symbol enumeration used on o_sequence and a
//                helper that returns the number of non-IDLE output symbols
//                emitted by one complete sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
package patseq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      A    = 2'd1,
      B    = 2'd2,
      C    = 2'd3
   } states_t;

   // Output symbols of one full sequence, excluding IDLE:
   // NUM_A A's, (NUM_A-1) runs of NUM_B B's, one closing C.
   function automatic int unsigned seq_len(input int unsigned num_a,
                                           input int unsigned num_b);
      return num_a + (num_a - 1) * num_b + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_seq_gen_sva.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_seq_gen_sva
//  Description : Passive property checker for pattern_seq_gen. Observes all
//                top-level I/O and keeps its own count of A symbols seen on
//                o_sequence since the last IDLE output.
//  Ports       : i_clk, i_rst, i_req, i_abort - generator inputs (observed)
//                i_sequence, i_running, i_done, i_a_seen - generator outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_seq_gen_sva
   import patseq_pkg::*;
#(
   parameter int NUM_A = 2,
   parameter int NUM_B = 3
) (
   input logic                         i_clk,
   input logic                         i_rst,
   input logic                         i_req,
   input logic                         i_abort,
   input states_t                      i_sequence,
   input logic                         i_running,
   input logic                         i_done,
   input logic [$clog2(NUM_A+1)-1:0]   i_a_seen
);

   localparam int AW = $clog2(NUM_A + 1);
   localparam logic [AW-1:0] c_a_max = AW'(NUM_A);
   localparam int c_len = int'(seq_len(NUM_A, NUM_B));

   logic [AW-1:0] mon_cnt_q, mon_cnt_d;
   int            run_len_q, run_len_d;

   // A symbols seen since the output last showed IDLE, and the number of
   // consecutive running cycles already elapsed before the current one.
   always_comb begin
      mon_cnt_d = mon_cnt_q;
      run_len_d = run_len_q;
      if (i_sequence == IDLE) begin
         mon_cnt_d = '0;
         run_len_d = 0;
      end else begin
         run_len_d = run_len_q + 1;
         if (i_sequence == A && mon_cnt_q < c_a_max) begin
            mon_cnt_d = mon_cnt_q + AW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mon_cnt_q <= '0;
         run_len_q <= 0;
      end else begin
         mon_cnt_q <= mon_cnt_d;
         run_len_q <= run_len_d;
      end
   end

   default clocking cb @(posedge i_clk);
   endclocking

   a_c_after_all_a : assert property (disable iff (i_rst)
      (i_sequence == C) |-> (mon_cnt_q == c_a_max));
   a_running_match : assert property (disable iff (i_rst)
      i_running == (i_sequence != IDLE));
   a_done_match    : assert property (disable iff (i_rst)
      i_done == (i_sequence == C));
   a_no_double_a   : assert property (disable iff (i_rst)
      (i_sequence == A) |=> (i_sequence != A));
   a_seen_bound    : assert property (disable iff (i_rst)
      i_a_seen <= c_a_max);
   a_len_bound     : assert property (disable iff (i_rst)
      i_running |-> (run_len_q < c_len));

   c_full_seq : cover property (disable iff (i_rst) i_done);
   c_abort    : cover property (disable iff (i_rst) i_running && i_abort);
   c_start    : cover property (disable iff (i_rst)
      (i_req && !i_running) ##2 (i_sequence == A));

endmodule
`default_nettype wire

// File: rtl/pattern_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_seq_gen
//  Description : Parametrised pattern generator. On request emits
//                A (B x NUM_B, A) x (NUM_A-1), C on a registered symbol
//                output, with abort, a completion pulse and an A counter.
//  Ports       : i_clk      - clock, rising edge
//                i_rst      - synchronous active-high reset
//                i_req      - start request, honoured only while idle
//                i_abort    - synchronous abort back to IDLE
//                o_sequence - current symbol (registered)
//                o_running  - high while o_sequence != IDLE
//                o_done     - one-cycle pulse coincident with C
//                o_a_seen   - A symbols emitted in current sequence
//  Config      : PATSEQ_SVA_EN - instantiates pattern_seq_gen_sva checker
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_seq_gen
   import patseq_pkg::*;
#(
   parameter int NUM_A = 2,
   parameter int NUM_B = 3
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_req,
   input  logic                         i_abort,
   output states_t                      o_sequence,
   output logic                         o_running,
   output logic                         o_done,
   output logic [$clog2(NUM_A+1)-1:0]   o_a_seen
);

   localparam int AW = $clog2(NUM_A + 1);
   localparam int BW = $clog2(NUM_B + 1);
   localparam logic [AW-1:0] c_a_last = AW'(NUM_A - 1);
   localparam logic [AW-1:0] c_a_max  = AW'(NUM_A);
   localparam logic [BW-1:0] c_b_last = BW'(NUM_B - 1);

   states_t       ps_q, ps_d;
   logic [AW-1:0] a_cnt_q, a_cnt_d;
   logic [BW-1:0] b_cnt_q, b_cnt_d;

   states_t       seq_q, seq_d;
   logic          run_q, run_d;
   logic          done_q, done_d;
   logic [AW-1:0] a_seen_q, a_seen_d;

   // Symbol sequencer
   always_comb begin
      ps_d    = ps_q;
      a_cnt_d = a_cnt_q;
      b_cnt_d = b_cnt_q;
      if (i_abort) begin
         ps_d    = IDLE;
         a_cnt_d = '0;
         b_cnt_d = '0;
      end else begin
         case (ps_q)
            IDLE: begin
               if (i_req) begin
                  ps_d = A;
               end
            end
            A: begin
               if (a_cnt_q == c_a_last) begin
                  ps_d    = C;
                  a_cnt_d = '0;
               end else begin
                  ps_d    = B;
                  a_cnt_d = a_cnt_q + AW'(1);
               end
            end
            B: begin
               if (b_cnt_q == c_b_last) begin
                  ps_d    = A;
                  b_cnt_d = '0;
               end else begin
                  b_cnt_d = b_cnt_q + BW'(1);
               end
            end
            C: begin
               ps_d = IDLE;
            end
            default: begin
               ps_d = IDLE;
            end
         endcase
      end
   end

   // Output stage: one register behind ps. o_a_seen advances in the same
   // cycle o_sequence becomes A, so it reads NUM_A throughout the C cycle.
   always_comb begin
      seq_d    = ps_q;
      run_d    = (ps_q != IDLE);
      done_d   = (ps_q == C);
      a_seen_d = a_seen_q;
      if (ps_q == IDLE) begin
         a_seen_d = '0;
      end else if (ps_q == A && a_seen_q < c_a_max) begin
         a_seen_d = a_seen_q + AW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ps_q     <= IDLE;
         a_cnt_q  <= '0;
         b_cnt_q  <= '0;
         seq_q    <= IDLE;
         run_q    <= 1'b0;
         done_q   <= 1'b0;
         a_seen_q <= '0;
      end else begin
         ps_q     <= ps_d;
         a_cnt_q  <= a_cnt_d;
         b_cnt_q  <= b_cnt_d;
         seq_q    <= seq_d;
         run_q    <= run_d;
         done_q   <= done_d;
         a_seen_q <= a_seen_d;
      end
   end

   assign o_sequence = seq_q;
   assign o_running  = run_q;
   assign o_done     = done_q;
   assign o_a_seen   = a_seen_q;

`ifdef PATSEQ_SVA_EN
   pattern_seq_gen_sva #(
      .NUM_A (NUM_A),
      .NUM_B (NUM_B)
   ) u_sva (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_req      (i_req),
      .i_abort    (i_abort),
      .i_sequence (seq_q),
      .i_running  (run_q),
      .i_done     (done_q),
      .i_a_seen   (a_seen_q)
   );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pattern_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_seq_gen
//  Description : Self-checking bench for pattern_seq_gen. Two instances
//                (NUM_A=2/NUM_B=3 and NUM_A=4/NUM_B=1) share stimulus and are
//                compared every cycle against a position-in-sequence model,
//                plus literal cycle-by-cycle expectations for key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_seq_gen;
   import patseq_pkg::*;

   logic    clk = 1'b0;
   logic    rst, req, abort;
   states_t seq0, seq1;
   logic    run0, run1, done0, done1;
   logic [1:0] seen0;
   logic [2:0] seen1;

   always #5 clk = ~clk;

   pattern_seq_gen #(.NUM_A(2), .NUM_B(3)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_abort(abort),
      .o_sequence(seq0), .o_running(run0), .o_done(done0), .o_a_seen(seen0)
   );

   pattern_seq_gen #(.NUM_A(4), .NUM_B(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_abort(abort),
      .o_sequence(seq1), .o_running(run1), .o_done(done1), .o_a_seen(seen1)
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   int      na [2] = '{2, 4};
   int      nb [2] = '{3, 1};
   int      pos [2];
   states_t e_seq [2];
   bit      e_run [2];
   bit      e_done [2];
   int      e_seen [2];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Symbol at position p of a sequence; p < 0 means not in a sequence.
   function automatic states_t sym(input int a, input int b, input int p);
      int len;
      len = a + (a - 1) * b + 1;
      if (p < 0)                return IDLE;
      if (p == len - 1)         return C;
      if (p % (b + 1) == 0)     return A;
      return B;
   endfunction

   // Model: pos is the index of the symbol currently held internally;
   // outputs show that symbol one cycle later.
   always @(posedge clk) begin
      states_t s;
      int      len;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            pos[k]    = -1;
            e_seq[k]  = IDLE;
            e_run[k]  = 1'b0;
            e_done[k] = 1'b0;
            e_seen[k] = 0;
         end else begin
            s         = sym(na[k], nb[k], pos[k]);
            e_seq[k]  = s;
            e_run[k]  = (s != IDLE);
            e_done[k] = (s == C);
            if (s == IDLE)                         e_seen[k] = 0;
            else if (s == A && e_seen[k] < na[k])  e_seen[k] = e_seen[k] + 1;
            len = na[k] + (na[k] - 1) * nb[k] + 1;
            if (abort)               pos[k] = -1;
            else if (pos[k] < 0)     pos[k] = req ? 0 : -1;
            else if (pos[k] == len-1) pos[k] = -1;
            else                     pos[k] = pos[k] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_seq0",  seq0,  e_seq[0]);
         chk("m_run0",  run0,  e_run[0]);
         chk("m_done0", done0, e_done[0]);
         chk("m_seen0", seen0, e_seen[0]);
         chk("m_seq1",  seq1,  e_seq[1]);
         chk("m_run1",  run1,  e_run[1]);
         chk("m_done1", done1, e_done[1]);
         chk("m_seen1", seen1, e_seen[1]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   states_t exp_s1 [8]  = '{IDLE, A, B, B, B, A, C, IDLE};
   int      exp_a1 [8]  = '{0, 1, 1, 1, 1, 2, 2, 0};
   states_t exp_s2 [11] = '{IDLE, A, B, A, B, A, B, A, C, IDLE, A};
   int      exp_a2 [11] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 1};

   initial begin
      rst = 1'b1; req = 1'b0; abort = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_seq0",  seq0,  IDLE);
      chk("rst_run0",  run0,  0);
      chk("rst_done0", done0, 0);
      chk("rst_seen1", seen1, 0);
      rst = 1'b0;
      tick();

      // Single request pulse
      req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         req = 1'b0;
         chk("pulse_seq0",  seq0,  exp_s1[c-1]);
         chk("pulse_seen0", seen0, exp_a1[c-1]);
         chk("pulse_done0", done0, (c == 7) ? 1 : 0);
      end
      repeat (6) tick();

      // Request held high: back-to-back on the 4/1 instance
      req = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         chk("held_seq1",  seq1,  exp_s2[c-1]);
         chk("held_seen1", seen1, exp_a2[c-1]);
      end
      req = 1'b0;
      repeat (20) tick();

      // Abort during B, then fresh request
      req = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         req   = (c == 8);
         abort = (c == 4);
         if (c <= 10) chk("abort_done0", done0, 0);
         if (c == 5)  chk("abort_seq0_c5", seq0, B);
         if (c == 6)  chk("abort_seq0_c6", seq0, IDLE);
         if (c == 10) chk("abort_seq0_c10", seq0, A);
      end
      abort = 1'b0; req = 1'b0;
      repeat (12) tick();

      // Reset mid-sequence, then restart
      req = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         req = (c == 7);
         rst = (c == 5);
         if (c == 6) begin
            chk("mrst_seq0",  seq0,  IDLE);
            chk("mrst_run0",  run0,  0);
            chk("mrst_done0", done0, 0);
            chk("mrst_seen0", seen0, 0);
            chk("mrst_seq1",  seq1,  IDLE);
         end
         if (c == 9) begin
            chk("mrst_restart_seq0",  seq0,  A);
            chk("mrst_restart_seen0", seen0, 1);
         end
      end
      req = 1'b0; rst = 1'b0;
      repeat (12) tick();

      // Request toggling during a sequence has no effect
      req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         req = (c % 2 == 0);
         chk("toggle_seq0", seq0, exp_s1[c-1]);
      end
      req = 1'b0;
      repeat (12) tick();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 99) == 0);
         abort = ($urandom_range(0, 31) == 0);
         req   = ($urandom_range(0, 2) != 0);
         tick();
      end
      rst = 1'b0; abort = 1'b0; req = 1'b0;
      repeat (15) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pattern_seq_gen.md
# pattern_seq_gen

Parametrised pattern generator, successor to the fixed A/B/C sequencer.
- On request it emits IDLE → A → (B × NUM_B → A) × (NUM_A−1) → C → IDLE on a registered symbol output.
- Adds abort, a completion pulse and a visit counter.
- Serves as a stimulus source and DUT for non-consecutive-repetition checking in formal and sim benches.

## Interface
- NUM_A, default 2: number of A symbols per sequence; legal range ≥ 2.
- NUM_B, default 3: consecutive B symbols between two A symbols; legal range ≥ 1.
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  start request, sampled only in IDLE.
- i_abort  in  1  synchronous abort; return to IDLE.
- o_sequence  out  states_t (2)  current symbol: IDLE/A/B/C, registered.
- o_running  out  1  high while o_sequence ≠ IDLE, registered.
- o_done  out  1  one-cycle pulse, coincident with o_sequence == C.
- o_a_seen  out  $clog2(NUM_A+1)  A symbols emitted in current sequence, registered.

## Operation
- State register ps: IDLE, A, B, C (states_t). Counters:
  - a_cnt, width $clog2(NUM_A+1).
  - b_cnt, width $clog2(NUM_B+1).
- IDLE:
  - i_req=1 → A. Otherwise stay in IDLE.
- A:
  - If a_cnt == NUM_A−1, go to C and clear a_cnt.
  - Otherwise increment a_cnt and go to B.
- B:
  - If b_cnt == NUM_B−1, go to A and clear b_cnt.
  - Otherwise increment b_cnt and stay in B.
- C → IDLE unconditionally.
- i_abort=1 in any state: next ps = IDLE, a_cnt = b_cnt = 0.
  - i_abort has priority over i_req and all transitions.
  - Output registers follow normally, one cycle later.
- i_req while ps ≠ IDLE: ignored. No queuing.
- Output register (one stage after ps):
  - o_sequence <= ps.
  - o_running <= (ps ≠ IDLE).
  - o_done <= (ps == C).
- o_a_seen:
  - Cleared when ps == IDLE.
  - Incremented on each cycle o_sequence becomes A.
  - Saturates at NUM_A.
  - Holds NUM_A during the C cycle.
- Counter arithmetic: unsigned, width-extended compares. Counters never exceed NUM_A−1 / NUM_B−1.

## Timing
- Reset values:
  - ps = IDLE, a_cnt = 0, b_cnt = 0.
  - o_sequence = IDLE, o_running = 0, o_done = 0, o_a_seen = 0.
- Latency:
  - i_req high at cycle t in IDLE → ps = A at t+1 → o_sequence = A at t+2.
  - Sequence length (output symbols, excl. IDLE) = NUM_A + (NUM_A−1)·NUM_B + 1.
  - o_done at t+2+NUM_A+(NUM_A−1)·NUM_B.
- Back-to-back: with i_req held high, exactly one IDLE symbol appears between C and the next A.
- A symbols are never consecutive. C only ever follows A.
- Reset mid-sequence: all state and outputs return to reset values at the next edge. No partial C or o_done.
- Abort on the same cycle as the C→IDLE transition: IDLE either way; o_done still pulses for that C.

## Configuration
- PATSEQ_SVA_EN defined: pattern_seq_gen_sva is instantiated. It carries:
  - Its own request-triggered A counter.
  - Default clocking on i_clk.
  - Disable iff i_rst.
  - Assertions:
    - Exactly NUM_A non-consecutive A symbols between acceptance and C.
    - o_sequence == C only when the monitor count == NUM_A.
    - o_running == (o_sequence ≠ IDLE).
    - o_done ↔ o_sequence == C.
    - No A immediately after A.
  - Covers: a full sequence; an abort.
- PATSEQ_SVA_EN undefined: no checker, no assertions. RTL behaviour is identical.

## Structure
- Shared package patseq_pkg holds:
  - typedef enum logic [1:0] {IDLE, A, B, C} states_t.
  - Helper function seq_len(NUM_A, NUM_B).
- Sub-module pattern_seq_gen_sva:
  - Checker only.
  - Read-only ports on all top-level I/O.
  - Instantiated under the macro.

## Test plan
- NUM_A=2, NUM_B=3; i_req pulse at cycle 0:
  - o_sequence = A,B,B,B,A,C over cycles 2–7.
  - o_done=1 at cycle 7.
  - IDLE from cycle 8.
- NUM_A=4, NUM_B=1; i_req held high:
  - A,B,A,B,A,B,A,C, then IDLE, then A.
  - o_a_seen counts 1..4 and is 0 in the IDLE cycle.
- NUM_A=2, NUM_B=3; i_abort at cycle 4 (ps=B):
  - o_sequence = IDLE at cycle 6.
  - o_done never asserts.
  - A fresh i_req at cycle 8 gives A at cycle 10.
- i_rst asserted at cycle 5 mid-sequence for one cycle:
  - All outputs at reset values from cycle 6.
  - Counters restart cleanly on the next i_req.
- i_req toggled every cycle during a sequence: sequence unaffected, identical to the first scenario.
- Build with PATSEQ_SVA_EN under formal with i_req unconstrained: all assertions prove, covers reachable.
